mem_port_arbiter: RTL

- Shared 128x8 unified instruction/data memory with four requester ports, arbitrated round-robin.
- Sits directly downstream of the processor core.
  - Port 0: instruction fetch (address = pc).
  - Port 1: data load/store.
  - Port 2: reserve/stack.
  - Port 3: display/syscall region (addresses 28-31).
- Serialises all accesses through one single-port RAM.
- Returns read data with a one-cycle ack pulse per completed access.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Four-port round-robin arbiter in front of one single-port
//            unified instruction/data RAM (2**ADDR_W x DATA_W). Every access
//            takes three cycles (IDLE -> ACCESS -> RESP). Completion is
//            signalled by a one-cycle ack pulse on the served port, together
//            with registered read data for reads.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1          system clock, rising edge
//   reset     in   1          asynchronous active-high reset
//   req       in   4          per-port request (bit p = port p)
//   we        in   4          per-port write enable (1 write, 0 read)
//   addr      in   4*ADDR_W   per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wdata     in   4*DATA_W   per-port write data, port p at [p*DATA_W +: DATA_W]
//   rdata     out  4*DATA_W   per-port registered read data
//   ack       out  4          one-cycle completion pulse per port
//   busy      out  1          high while a transaction is in flight
//   grant_id  out  2          port currently or most recently served
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [4*DATA_W-1:0]   rdata,
  output logic [3:0]            ack,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  localparam int c_depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // Round-robin pointer and the transaction latched at grant time
  logic [1:0]          r_last_grant;
  logic [1:0]          r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;

  // Arbitration result
  logic [1:0]          w_winner;
  logic                w_found;
  logic [1:0]          w_idx;

  // Registered-output next values
  logic [3:0]          w_ack_next;

  // Storage: deliberately not reset so contents survive a reset pulse
  logic [DATA_W-1:0]   r_mem [c_depth];

  // --------------------------------------------------------------------------
  // Round-robin winner: first requesting port searching upward from the port
  // after the last one served. The last candidate (offset 4 wraps to 0) is
  // the previous winner itself, so a lone requester is always served.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_idx    = r_last_grant;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_ack_next   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        // ack is registered: it becomes visible in the cycle after RESP,
        // together with the updated rdata slice.
        w_ack_next[r_port] = 1'b1;
        w_next_state       = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register, transaction latch and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 2'd3;
      r_port       <= 2'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      grant_id     <= 2'd0;
      ack          <= '0;
      rdata        <= '0;
    end else begin
      r_state <= w_next_state;
      ack     <= w_ack_next;

      if (r_state == ST_IDLE && w_found) begin
        r_port   <= w_winner;
        r_we     <= we[w_winner];
        r_addr   <= addr[w_winner*ADDR_W +: ADDR_W];
        r_wdata  <= wdata[w_winner*DATA_W +: DATA_W];
        grant_id <= w_winner;
      end

      if (r_state == ST_RESP) begin
        r_last_grant <= r_port;
        if (!r_we) begin
          rdata[r_port*DATA_W +: DATA_W] <= r_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Single-port RAM cycle. A reset raised before the ACCESS edge has already
  // forced the state back to IDLE asynchronously, so an interrupted write
  // never reaches the array.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == ST_ACCESS) begin
      if (r_we) begin
        r_mem[r_addr] <= r_wdata;
      end else begin
        r_data <= r_mem[r_addr];
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
